mem_bus_ctrl: RTL and testbench

Sequencer that sits directly upstream of the mmu and turns CPU load/store requests into mmu bus cycles. Requests are byte, half or word sized and carry byte addresses. Each request becomes a word-aligned 32-bit access with strictly non-overlapping N_OE/N_WE strobes. Sub-word stores use read-modify-write; loads are lane-shifted and sign/zero extended; misaligned requests fault without touching the bus.

---
 rtl/mem_bus_ctrl_if.sv | 26 ++
 rtl/mem_bus_ctrl.sv | 85 ++++++++
 tb/tb_mem_bus_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if: CPU request/response handshake plus mmu bus signals of the memory sequencer
interface mem_bus_ctrl_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_SIGNED;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_DATA;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        RSP_FAULT;
  logic [31:0] MEM_ADDR;
  logic        MEM_N_OE;
  logic        MEM_N_WE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  modport slave (
    input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_DATA, MEM_RDATA,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_FAULT, MEM_ADDR, MEM_N_OE, MEM_N_WE, MEM_WDATA
  );
  modport master (
    output REQ_VALID, REQ_WE, REQ_SIZE, REQ_SIGNED, REQ_ADDR, REQ_DATA, MEM_RDATA,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_FAULT, MEM_ADDR, MEM_N_OE, MEM_N_WE, MEM_WDATA
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: turns byte/half/word CPU loads and stores into word-aligned mmu cycles with read-modify-write for sub-word stores
module mem_bus_ctrl #(
  parameter logic [31:0] BOOT_ADDR = 32'h0
) (
  input logic          CLK,
  input logic          N_RST,
  mem_bus_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, TURN, WR, WR_REL, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rsp_data;
  logic [15:0] r_data;
  logic [1:0]  r_size;
  logic        r_signed, r_fault;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load, w_merge;
  assign w_fault = bus.REQ_SIZE == 2'd3 || (bus.REQ_SIZE == 2'd1 && bus.REQ_ADDR[0]) ||
                   (bus.REQ_SIZE == 2'd2 && |bus.REQ_ADDR[1:0]);
  // state register; reset abandons any access in flight
  always_ff @(posedge CLK)
    r_state <= N_RST ? IDLE : w_next;
  // next-state decode: requests branch from IDLE, every other state is a fixed one-cycle step
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.REQ_VALID) w_next = w_fault ? RESP : !bus.REQ_WE ? RD : bus.REQ_SIZE == 2'd2 ? WR : RMW_RD;
      RD:      w_next = RESP;
      RMW_RD:  w_next = TURN;
      TURN:    w_next = WR;
      WR:      w_next = WR_REL;
      WR_REL:  w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  // load lane select and extension, plus store-lane merge into the word just read
  always_comb begin
    w_byte  = bus.MEM_RDATA[{r_addr[1:0], 3'b000} +: 8];
    w_half  = r_addr[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0];
    w_load  = r_size == 2'd0 ? {{24{r_signed & w_byte[7]}}, w_byte} :
              r_size == 2'd1 ? {{16{r_signed & w_half[15]}}, w_half} : bus.MEM_RDATA;
    w_merge = bus.MEM_RDATA;
    if (r_size == 2'd0) w_merge[{r_addr[1:0], 3'b000} +: 8] = r_data[7:0];
    else w_merge[{r_addr[1], 4'b0000} +: 16] = r_data[15:0];
  end
  // request latch at accept, read capture at the end of RD, write data at accept or after the RMW read
  always_ff @(posedge CLK) begin
    if (N_RST) begin
      r_addr     <= BOOT_ADDR;
      r_data     <= 16'h0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_fault    <= 1'b0;
      r_wdata    <= 32'h0;
      r_rsp_data <= 32'h0;
    end else begin
      case (r_state)
        IDLE: if (bus.REQ_VALID) begin
          r_addr     <= bus.REQ_ADDR;
          r_data     <= bus.REQ_DATA[15:0];
          r_size     <= bus.REQ_SIZE;
          r_signed   <= bus.REQ_SIGNED;
          r_fault    <= w_fault;
          r_rsp_data <= 32'h0;
          if (!w_fault && bus.REQ_WE && bus.REQ_SIZE == 2'd2) r_wdata <= bus.REQ_DATA;
        end
        RD:      r_rsp_data <= w_load;
        RMW_RD:  r_wdata <= w_merge;
        default: ;
      endcase
    end
  end
  // outputs decode from registered state only, so the strobes can never overlap or glitch from inputs
  always_comb begin
    bus.REQ_READY = r_state == IDLE && !N_RST;
    bus.RSP_VALID = r_state == RESP;
    bus.RSP_DATA  = r_state == RESP ? r_rsp_data : 32'h0;
    bus.RSP_FAULT = r_state == RESP && r_fault;
    bus.MEM_ADDR  = r_state == IDLE ? BOOT_ADDR : {r_addr[31:2], 2'b00};
    bus.MEM_N_OE  = !(r_state == RD || r_state == RMW_RD);
    bus.MEM_N_WE  = r_state != WR;
    bus.MEM_WDATA = r_wdata;
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven check of mem_bus_ctrl against a word memory model and a response scoreboard
module tb_mem_bus_ctrl;
  logic CLK = 1'b0;
  logic N_RST = 1'b1;
  mem_bus_ctrl_if bus();
  mem_bus_ctrl dut (.CLK(CLK), .N_RST(N_RST), .bus(bus));
  always #5 CLK = ~CLK;
  logic [31:0] mem [64];
  always @(posedge CLK) if (!bus.MEM_N_WE) mem[bus.MEM_ADDR[7:2]] <= bus.MEM_WDATA;
  assign bus.MEM_RDATA = bus.MEM_N_OE ? 32'h0 : mem[bus.MEM_ADDR[7:2]];
  int ov_cnt = 0;
  always @(negedge CLK) if (!bus.MEM_N_OE && !bus.MEM_N_WE) ov_cnt++;
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          lat;
    int          n_oe;
    int          n_we;
    logic [31:0] exp_wd;
  } vec_t;
  typedef struct {
    logic [31:0] data;
    logic        fault;
  } rsp_t;
  vec_t tv[$];
  rsp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp_data,
                              input logic exp_fault, input int lat, input int n_oe, input int n_we,
                              input logic [31:0] exp_wd);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.data = data;
    v.exp_data = exp_data; v.exp_fault = exp_fault; v.lat = lat;
    v.n_oe = n_oe; v.n_we = n_we; v.exp_wd = exp_wd;
    return v;
  endfunction
  task automatic wait_ready(input string tag);
    for (int w = 0; w < 20 && !bus.REQ_READY; w++) @(negedge CLK);
    chk({tag, "/ready"}, {31'h0, bus.REQ_READY}, 32'h1);
  endtask
  task automatic do_req(input string tag, input vec_t v);
    int n, n_oe, n_we, oe_at, we_at;
    logic [31:0] oe_a, we_a, wd, wd_hold;
    rsp_t r;
    n_oe = 0; n_we = 0; oe_at = 0; we_at = 0;
    oe_a = 32'h0; we_a = 32'h0; wd = 32'h0; wd_hold = 32'h0;
    wait_ready(tag);
    chk({tag, "/idle_addr"}, bus.MEM_ADDR, 32'h0);
    bus.REQ_WE = v.we; bus.REQ_SIZE = v.size; bus.REQ_SIGNED = v.sgn;
    bus.REQ_ADDR = v.addr; bus.REQ_DATA = v.data; bus.REQ_VALID = 1'b1;
    sb.push_back('{v.exp_data, v.exp_fault});
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR = 32'hFFFF_FFFF; bus.REQ_DATA = 32'hA5A5_A5A5;
    n = 1;
    while (!bus.RSP_VALID && n < 20) begin
      if (!bus.MEM_N_OE) begin n_oe++; oe_at = n; oe_a = bus.MEM_ADDR; end
      if (!bus.MEM_N_WE) begin n_we++; we_at = n; we_a = bus.MEM_ADDR; wd = bus.MEM_WDATA; end
      if (we_at != 0 && n == we_at + 1) wd_hold = bus.MEM_WDATA;
      @(negedge CLK);
      n++;
    end
    chk({tag, "/rsp_valid"}, {31'h0, bus.RSP_VALID}, 32'h1);
    r = sb.pop_front();
    chk({tag, "/rsp_data"}, bus.RSP_DATA, r.data);
    chk({tag, "/rsp_fault"}, {31'h0, bus.RSP_FAULT}, {31'h0, r.fault});
    chk({tag, "/latency"}, n, v.lat);
    chk({tag, "/n_oe"}, n_oe, v.n_oe);
    chk({tag, "/n_we"}, n_we, v.n_we);
    if (v.n_oe != 0) chk({tag, "/oe_addr"}, oe_a, v.addr & 32'hFFFF_FFFC);
    if (v.n_we != 0) begin
      chk({tag, "/we_addr"}, we_a, v.addr & 32'hFFFF_FFFC);
      chk({tag, "/wdata"}, wd, v.exp_wd);
      chk({tag, "/wdata_hold"}, wd_hold, v.exp_wd);
    end
    if (v.n_oe != 0 && v.n_we != 0) chk({tag, "/rmw_gap"}, we_at - oe_at, 2);
    chk({tag, "/no_overlap"}, ov_cnt, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tv.push_back(mk(1, 2, 0, 'h10, 'hDEADBEEF, 'h0,        0, 3, 0, 1, 'hDEADBEEF));
    tv.push_back(mk(0, 2, 0, 'h10, 'h0,        'hDEADBEEF, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(1, 2, 0, 'h10, 'h80FF7F01, 'h0,        0, 3, 0, 1, 'h80FF7F01));
    tv.push_back(mk(0, 0, 1, 'h13, 'h0,        'hFFFFFF80, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 0, 0, 'h13, 'h0,        'h00000080, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 1, 1, 'h10, 'h0,        'h00007F01, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 1, 0, 'h12, 'h0,        'h000080FF, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 1, 1, 'h12, 'h0,        'hFFFF80FF, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 0, 1, 'h11, 'h0,        'h0000007F, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 0, 1, 'h12, 'h0,        'hFFFFFFFF, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(1, 2, 0, 'h20, 'h11223344, 'h0,        0, 3, 0, 1, 'h11223344));
    tv.push_back(mk(1, 0, 1, 'h21, 'hFFFFFFAB, 'h0,        0, 5, 1, 1, 'h1122AB44));
    tv.push_back(mk(0, 2, 0, 'h20, 'h0,        'h1122AB44, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(1, 1, 0, 'h22, 'h1234BEEF, 'h0,        0, 5, 1, 1, 'hBEEFAB44));
    tv.push_back(mk(0, 2, 1, 'h20, 'h0,        'hBEEFAB44, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(1, 2, 0, 'h30, 'hCAFEF00D, 'h0,        0, 3, 0, 1, 'hCAFEF00D));
    tv.push_back(mk(0, 1, 0, 'h31, 'h0,        'h0,        1, 1, 0, 0, 'h0));
    tv.push_back(mk(1, 2, 0, 'h32, 'h55555555, 'h0,        1, 1, 0, 0, 'h0));
    tv.push_back(mk(0, 3, 0, 'h30, 'h0,        'h0,        1, 1, 0, 0, 'h0));
    tv.push_back(mk(1, 3, 0, 'h30, 'h55555555, 'h0,        1, 1, 0, 0, 'h0));
    tv.push_back(mk(1, 1, 0, 'h33, 'h00005555, 'h0,        1, 1, 0, 0, 'h0));
    tv.push_back(mk(0, 2, 0, 'h30, 'h0,        'hCAFEF00D, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(1, 0, 0, 'h30, 'h0000007E, 'h0,        0, 5, 1, 1, 'hCAFEF07E));
    tv.push_back(mk(0, 0, 0, 'h30, 'h0,        'h0000007E, 0, 2, 1, 0, 'h0));
    tv.push_back(mk(0, 0, 1, 'h33, 'h0,        'hFFFFFFCA, 0, 2, 1, 0, 'h0));
    bus.REQ_VALID = 1'b1; bus.REQ_WE = 1'b1; bus.REQ_SIZE = 2'd2; bus.REQ_SIGNED = 1'b0;
    bus.REQ_ADDR = 32'h10; bus.REQ_DATA = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst/ready", {31'h0, bus.REQ_READY}, 32'h0);
      chk("rst/n_oe", {31'h0, bus.MEM_N_OE}, 32'h1);
      chk("rst/n_we", {31'h0, bus.MEM_N_WE}, 32'h1);
      chk("rst/rsp_valid", {31'h0, bus.RSP_VALID}, 32'h0);
    end
    chk("rst/mem_addr", bus.MEM_ADDR, 32'h0);
    chk("rst/mem_wdata", bus.MEM_WDATA, 32'h0);
    chk("rst/rsp_data", bus.RSP_DATA, 32'h0);
    bus.REQ_VALID = 1'b0;
    N_RST = 1'b0;
    #1;
    chk("rst/ready_after", {31'h0, bus.REQ_READY}, 32'h1);
    foreach (tv[i]) do_req($sformatf("v%0d", i), tv[i]);
    wait_ready("midrst");
    bus.REQ_WE = 1'b1; bus.REQ_SIZE = 2'd2; bus.REQ_SIGNED = 1'b0;
    bus.REQ_ADDR = 32'h40; bus.REQ_DATA = 32'h1234_5678; bus.REQ_VALID = 1'b1;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    chk("midrst/we_low", {31'h0, bus.MEM_N_WE}, 32'h0);
    N_RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("midrst/n_we", {31'h0, bus.MEM_N_WE}, 32'h1);
      chk("midrst/rsp_valid", {31'h0, bus.RSP_VALID}, 32'h0);
      chk("midrst/ready", {31'h0, bus.REQ_READY}, 32'h0);
    end
    chk("midrst/mem_addr", bus.MEM_ADDR, 32'h0);
    N_RST = 1'b0;
    #1;
    chk("midrst/ready_after", {31'h0, bus.REQ_READY}, 32'h1);
    @(negedge CLK);
    chk("midrst/no_rsp", {31'h0, bus.RSP_VALID}, 32'h0);
    chk("midrst/sb_empty", sb.size(), 0);
    do_req("post", mk(0, 2, 0, 'h10, 'h0, 'h80FF7F01, 0, 2, 1, 0, 'h0));
    chk("end/sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
